// File: rtl/memory_initiator_if.sv
// Command, memory-side and response signals of the memory initiator.
// The master modport is the initiator's view; the slave modport is the
// view of whatever drives commands, answers as the responder and takes
// responses.
interface memory_initiator_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    // Command channel
    logic                  cmdValid;
    logic                  cmdReady;
    logic [ADDR_WIDTH-1:0] cmdAddress;
    logic [DATA_WIDTH-1:0] cmdWdata;
    logic                  cmdWnR;
    // Memory responder side
    logic [ADDR_WIDTH-1:0] outputAddress;
    logic [DATA_WIDTH-1:0] outputWdata;
    logic                  outputWnR;
    logic                  outputSelect;
    logic [DATA_WIDTH-1:0] inputRdata;
    logic                  inputValid;
    // Response channel
    logic                  rspValid;
    logic                  rspReady;
    logic [DATA_WIDTH-1:0] rspRdata;
    logic                  rspError;

    modport master (
        input  cmdValid, cmdAddress, cmdWdata, cmdWnR,
        output cmdReady,
        output outputAddress, outputWdata, outputWnR, outputSelect,
        input  inputRdata, inputValid,
        output rspValid, rspRdata, rspError,
        input  rspReady
    );

    modport slave (
        output cmdValid, cmdAddress, cmdWdata, cmdWnR,
        input  cmdReady,
        input  outputAddress, outputWdata, outputWnR, outputSelect,
        output inputRdata, inputValid,
        input  rspValid, rspRdata, rspError,
        output rspReady
    );
endinterface

// File: rtl/memory_initiator.sv
// Single-outstanding bus initiator for the select/valid memory interface.
// Takes one command, raises select until the responder's valid pulse (or
// a timeout), then holds the response until it is consumed. Every output
// comes straight from a register.
module memory_initiator #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                rst,
    memory_initiator_if.master  bus
);

    // Counter wide enough to hold TIMEOUT; at least one bit when disabled.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  sel_q,       sel_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic                  wnr_q,       wnr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    // State register and all registered outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wnr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wnr_q       <= wnr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wnr_d       = wnr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmdValid && cmd_ready_q) begin
                    addr_d  = bus.cmdAddress;
                    wdata_d = bus.cmdWdata;
                    wnr_d   = bus.cmdWnR;
                    sel_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Completion beats a simultaneous timeout. Select drops on the
                // same edge so the responder never sees a second access.
                if (bus.inputValid) begin
                    rsp_rdata_d = wnr_q ? '0 : bus.inputRdata;
                    rsp_error_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    sel_d       = 1'b0;
                    state_d     = ST_RSP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LIMIT)) begin
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    sel_d       = 1'b0;
                    state_d     = ST_RSP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RSP: begin
                if (bus.rspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 1'b0;
            end
        endcase

        // Ready is registered, so a response handshake can never overlap a
        // command handshake: ready only rises the cycle after leaving RSP.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    assign bus.cmdReady      = cmd_ready_q;
    assign bus.outputSelect  = sel_q;
    assign bus.outputAddress = addr_q;
    assign bus.outputWdata   = wdata_q;
    assign bus.outputWnR     = wnr_q;
    assign bus.rspValid      = rsp_valid_q;
    assign bus.rspRdata      = rsp_rdata_q;
    assign bus.rspError      = rsp_error_q;

endmodule

// File: tb/tb_memory_initiator.sv
// Directed bench for memory_initiator with a one-cycle registered
// responder model, a spurious-valid injector and hand-computed expectations.
module tb_memory_initiator;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    memory_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder model: answers one select with a single valid pulse.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          rv_q;
    logic [DW-1:0] rd_q;
    logic          resp_en;
    logic          spur;

    always @(posedge clk) begin
        if (rst) begin
            rv_q <= 1'b0;
        end else if (resp_en && bus.outputSelect && !rv_q) begin
            rv_q <= 1'b1;
            if (bus.outputWnR) mem[bus.outputAddress] <= bus.outputWdata;
            rd_q <= mem[bus.outputAddress];
        end else begin
            rv_q <= 1'b0;
        end
    end

    assign bus.inputValid = rv_q | spur;
    assign bus.inputRdata = spur ? 16'hDEAD : rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One command; returns at the negedge where rspValid is first seen.
    task automatic txn(input logic wnr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd, output logic er, output int lat, output int hs);
        int n;
        n = 0;
        while (!bus.cmdReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", {31'd0, bus.cmdReady}, 32'd1);
        bus.cmdValid   = 1'b1;
        bus.cmdWnR     = wnr;
        bus.cmdAddress = a;
        bus.cmdWdata   = d;
        hs = cyc;
        @(negedge clk);
        bus.cmdValid = 1'b0;
        lat = 1;
        chk("req_sel",  {31'd0, bus.outputSelect}, 32'd1);
        chk("req_addr", {20'd0, bus.outputAddress}, {20'd0, a});
        chk("req_wnr",  {31'd0, bus.outputWnR}, {31'd0, wnr});
        if (wnr) chk("req_wdata", {16'd0, bus.outputWdata}, {16'd0, d});
        chk("req_cmdrdy", {31'd0, bus.cmdReady}, 32'd0);
        while (!bus.rspValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_seen", {31'd0, bus.rspValid}, 32'd1);
        chk("sel_drop", {31'd0, bus.outputSelect}, 32'd0);
        rd = bus.rspRdata;
        er = bus.rspError;
    endtask

    logic [DW-1:0] rd;
    logic          er;
    int            lat, hs, hs_prev;

    initial begin
        rst            = 1'b1;
        resp_en        = 1'b1;
        spur           = 1'b0;
        bus.cmdValid   = 1'b0;
        bus.cmdAddress = '0;
        bus.cmdWdata   = '0;
        bus.cmdWnR     = 1'b0;
        bus.rspReady   = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmdrdy", {31'd0, bus.cmdReady}, 32'd1);
        chk("rst_sel",    {31'd0, bus.outputSelect}, 32'd0);
        chk("rst_wnr",    {31'd0, bus.outputWnR}, 32'd0);
        chk("rst_addr",   {20'd0, bus.outputAddress}, 32'd0);
        chk("rst_wdata",  {16'd0, bus.outputWdata}, 32'd0);
        chk("rst_rspv",   {31'd0, bus.rspValid}, 32'd0);
        chk("rst_rdata",  {16'd0, bus.rspRdata}, 32'd0);
        chk("rst_err",    {31'd0, bus.rspError}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back 0x00A
        txn(1'b1, 12'h00A, 16'h1234, rd, er, lat, hs);
        chk("w_lat",   lat, 3);
        chk("w_rdata", {16'd0, rd}, 32'd0);
        chk("w_err",   {31'd0, er}, 32'd0);
        txn(1'b0, 12'h00A, 16'h0000, rd, er, lat, hs);
        chk("r_lat",   lat, 3);
        chk("r_rdata", {16'd0, rd}, 32'h1234);
        chk("r_err",   {31'd0, er}, 32'd0);

        // Back-to-back traffic at one transaction per four cycles
        txn(1'b1, 12'hFFF, 16'hAAAA, rd, er, lat, hs);
        hs_prev = hs;
        txn(1'b1, 12'hFFE, 16'h5555, rd, er, lat, hs);
        chk("b2b_gap1", hs - hs_prev, 4);
        hs_prev = hs;
        txn(1'b0, 12'hFFF, 16'h0000, rd, er, lat, hs);
        chk("b2b_gap2", hs - hs_prev, 4);
        chk("b2b_rd0",  {16'd0, rd}, 32'hAAAA);
        hs_prev = hs;
        txn(1'b0, 12'hFFE, 16'h0000, rd, er, lat, hs);
        chk("b2b_gap3", hs - hs_prev, 4);
        chk("b2b_rd1",  {16'd0, rd}, 32'h5555);
        @(negedge clk);

        // Response held under back-pressure, with a spurious valid in RSP
        bus.rspReady = 1'b0;
        txn(1'b0, 12'hFFF, 16'h0000, rd, er, lat, hs);
        chk("bp_rdata0", {16'd0, rd}, 32'hAAAA);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
            chk("bp_rspv",   {31'd0, bus.rspValid}, 32'd1);
            chk("bp_rdata",  {16'd0, bus.rspRdata}, 32'hAAAA);
            chk("bp_cmdrdy", {31'd0, bus.cmdReady}, 32'd0);
            chk("bp_sel",    {31'd0, bus.outputSelect}, 32'd0);
        end
        bus.rspReady = 1'b1;
        @(negedge clk);
        chk("bp_rel_rspv",   {31'd0, bus.rspValid}, 32'd0);
        chk("bp_rel_cmdrdy", {31'd0, bus.cmdReady}, 32'd1);

        // Missing responder: timeout sixteen cycles after select rises
        resp_en = 1'b0;
        txn(1'b0, 12'h005, 16'h0000, rd, er, lat, hs);
        chk("to_lat",   lat, 17);
        chk("to_err",   {31'd0, er}, 32'd1);
        chk("to_rdata", {16'd0, rd}, 32'd0);
        resp_en = 1'b1;
        @(negedge clk);

        // Spurious valid while IDLE
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("idle_sp_cmdrdy", {31'd0, bus.cmdReady}, 32'd1);
        chk("idle_sp_sel",    {31'd0, bus.outputSelect}, 32'd0);
        chk("idle_sp_rspv",   {31'd0, bus.rspValid}, 32'd0);
        chk("idle_sp_rdata",  {16'd0, bus.rspRdata}, 32'd0);

        // Reset in the middle of REQ, then normal operation resumes
        txn(1'b1, 12'h090, 16'hBEEF, rd, er, lat, hs);
        chk("pre_w_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        resp_en        = 1'b0;
        bus.cmdValid   = 1'b1;
        bus.cmdWnR     = 1'b0;
        bus.cmdAddress = 12'h090;
        @(negedge clk);
        bus.cmdValid = 1'b0;
        chk("mid_req_sel", {31'd0, bus.outputSelect}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_sel",    {31'd0, bus.outputSelect}, 32'd0);
        chk("rst_req_rspv",   {31'd0, bus.rspValid}, 32'd0);
        chk("rst_req_cmdrdy", {31'd0, bus.cmdReady}, 32'd1);
        rst     = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        txn(1'b0, 12'h090, 16'h0000, rd, er, lat, hs);
        chk("post_rst_lat",   lat, 3);
        chk("post_rst_rdata", {16'd0, rd}, 32'hBEEF);
        chk("post_rst_err",   {31'd0, er}, 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_initiator.md
# memory_initiator

Bus initiator for the single-port select/valid memory interface. It accepts one read or write command at a time from a CPU-side command channel and drives address, write data, write-not-read and select toward the memory responder. It waits for the responder's one-cycle valid pulse, then returns read data or a write acknowledgement on a response channel. A timeout guards against a missing responder.

## Interface
- ADDR_WIDTH, 12: memory word address width.
- DATA_WIDTH, 16: data width.
- TIMEOUT, 15: maximum cycles in REQ before aborting; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmdValid  input  1  command present.
- cmdReady  output  1  command accepted when both cmdValid and cmdReady are high.
- cmdAddress  input  ADDR_WIDTH  word address.
- cmdWdata  input  DATA_WIDTH  write data; ignored for reads.
- cmdWnR  input  1  1 = write, 0 = read.
- outputAddress  output  ADDR_WIDTH  address to the responder.
- outputWdata  output  DATA_WIDTH  write data to the responder.
- outputWnR  output  1  write-not-read to the responder.
- outputSelect  output  1  request strobe to the responder.
- inputRdata  input  DATA_WIDTH  read data from the responder.
- inputValid  input  1  one-cycle completion pulse from the responder.
- rspValid  output  1  response present.
- rspReady  input  1  response consumed when both rspValid and rspReady are high.
- rspRdata  output  DATA_WIDTH  captured read data; 0 for writes and timeouts.
- rspError  output  1  1 means the transaction timed out.

## Operation
- Three states: IDLE, REQ and RSP. All outputs are registered.
- **IDLE**
  - cmdReady = 1; outputSelect = 0; rspValid = 0.
  - On a command handshake: latch address, wdata and WnR onto the output* ports, set outputSelect = 1, clear the timeout counter, go to REQ.
- **REQ**
  - outputSelect, outputAddress, outputWdata and outputWnR are held stable. cmdReady = 0.
  - On inputValid = 1:
    - rspRdata = inputRdata for a read, 0 for a write.
    - rspError = 0, rspValid = 1.
    - outputSelect = 0 on the same edge, go to RSP.
  - The responder re-executes if select is still high after its valid pulse. Select must therefore drop on the edge that samples inputValid.
  - Timeout counter: ceil(log2(TIMEOUT+1)) bits, incremented every REQ cycle without inputValid.
    - When the counter reaches TIMEOUT with no inputValid: outputSelect = 0, rspValid = 1, rspError = 1, rspRdata = 0, go to RSP.
    - If inputValid arrives in the same cycle as the timeout, inputValid wins.
- **RSP**
  - rspValid and rspRdata are held until rspReady = 1. On that handshake: rspValid = 0, go to IDLE.
  - cmdReady = 0 while in RSP. Commands are never accepted in the same cycle as a response handshake.
- inputValid is ignored in IDLE and RSP. A spurious pulse causes no state or output change.
- outputSelect is low for at least one cycle between consecutive transactions.
- Reset values: state = IDLE, cmdReady = 1, outputSelect = 0, outputWnR = 0, outputAddress = 0, outputWdata = 0, rspValid = 0, rspRdata = 0, rspError = 0, counter = 0.
- Reset asserted mid-REQ or mid-RSP: the transaction is abandoned and no response is issued. outputSelect is 0 on the edge after rst is sampled high.

## Timing
- Command handshake on edge E0. outputSelect = 1 during cycle E0+1.
- Responder: valid at E0+2 (one-cycle registered latency). The initiator samples it at the end of that cycle.
- rspValid = 1 and outputSelect = 0 from E0+3. Command-to-response latency is 3 cycles with a single-cycle responder.
- With rspReady held high: IDLE again at E0+4, next command accepted at E0+4. Sustained throughput is 1 transaction per 4 cycles.
- The write commits in the responder at the end of the first select cycle. The initiator never asserts select for a second consecutive access.
- Timeout: with no inputValid, rspError = 1 appears TIMEOUT+1 cycles after outputSelect rises.

## Test plan
- Write 0x1234 to 0x00A, then read 0x00A (bench responder model) -> write response rspRdata = 0, rspError = 0; read response rspRdata = 0x1234; outputSelect high exactly 1 cycle per transaction.
- Back-to-back writes 0xFFF = 0xAAAA and 0xFFE = 0x5555, rspReady tied high, then reads of both -> 0xAAAA, 0x5555; each command accepted 4 cycles after the previous one; select low ≥1 cycle between transactions.
- Read with rspReady held low for 5 cycles -> rspValid and rspRdata stable for all 5 cycles; cmdReady = 0 throughout; IDLE the cycle after rspReady rises.
- Responder disconnected (inputValid = 0), TIMEOUT = 15 -> rspError = 1 and rspRdata = 0 sixteen cycles after select rises; select = 0 from then on.
- rst pulsed while in REQ -> outputSelect = 0 and rspValid = 0 on the next edge; a subsequent read of 0x090 completes normally.
- inputValid pulsed during IDLE and during RSP -> no state change; rspRdata is unchanged.
